matmul_apb_initiator: RTL
=========================

// Module: matmul_apb_initiator
// PURPOSE
// - APB requester driving the matmul accelerator's APB target port: converts simple
//   valid/ready register requests (load A/B operands, write control, poll status,
//   read C results) into APB SETUP/ACCESS transfers and returns one response each.
// - Sits between the testbench/host sequencer and the matmul_calc APB target.
// PARAMETERS
// - ADDR_WIDTH   32  paddr / req_addr_i width
// - BUS_WIDTH    32  pwdata / prdata / req_wdata_i / rsp_rdata_o width (multiple of 8)
// - TIMEOUT_CYC  64  max ACCESS cycles waiting for pready (used only with APB_TIMEOUT_EN)
// PORTS
// - clk_i          in   1               clock, rising edge
// - rst_ni         in   1               asynchronous active-low reset
// - req_valid_i    in   1               request valid
// - req_ready_o    out  1               request accepted when valid&ready
// - req_write_i    in   1               1=write, 0=read
// - req_addr_i     in   ADDR_WIDTH      byte address
// - req_wdata_i    in   BUS_WIDTH       write data
// - req_strb_i     in   BUS_WIDTH/8     write byte strobes (ignored on reads)
// - rsp_valid_o    out  1               response valid, held until rsp_ready_i
// - rsp_ready_i    in   1               response consumed when valid&ready
// - rsp_rdata_o    out  BUS_WIDTH       read data (0 for writes)
// - rsp_slverr_o   out  1               pslverr (or timeout) of the transfer
// - psel_o         out  1               APB select (single target)
// - penable_o      out  1               APB enable
// - pwrite_o       out  1               APB direction
// - paddr_o        out  ADDR_WIDTH      APB address
// - pwdata_o       out  BUS_WIDTH       APB write data
// - pstrb_o        out  BUS_WIDTH/8     APB strobes
// - prdata_i       in   BUS_WIDTH       APB read data
// - pready_i       in   1               APB ready
// - pslverr_i      in   1               APB error
// BEHAVIOUR
// - Reset (async, rst_ni=0): all outputs 0; state IDLE; psel_o/penable_o drop
//   immediately even mid-transfer; no response is generated for the aborted transfer.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; one outstanding transfer max.
// - IDLE: req_ready_o=1 (only state where it is 1). On valid&ready latch write/addr/
//   wdata/strb (strb forced 0 on reads) -> SETUP.
// - SETUP: psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb from latch; 1 cycle -> ACCESS.
// - ACCESS: psel_o=1, penable_o=1, address/data stable. Stay while pready_i=0.
//   On pready_i=1: capture prdata_i (reads; 0 on writes) and pslverr_i -> RESP.
// - RESP: psel_o=penable_o=0; rsp_valid_o=1, rsp_rdata_o/rsp_slverr_o stable until
//   rsp_ready_i=1 -> IDLE. rsp_ready_i outside RESP is ignored.
// - Latency: request accept to rsp_valid_o = 3 cycles with zero wait states; +1 per
//   pready_i=0 cycle. Minimum 4 cycles per transaction (accept..consume back to IDLE).
// - paddr_o/pwrite_o/pwdata_o/pstrb_o hold last values outside SETUP/ACCESS.
// - pslverr_i sampled only with pready_i=1 in ACCESS; passed through unmodified.
// CONFIGURATION
// - APB_TIMEOUT_EN defined: counter cleared on entering ACCESS, +1 per cycle with
//   pready_i=0; when it reaches TIMEOUT_CYC the transfer is abandoned -> RESP with
//   rsp_slverr_o=1, rsp_rdata_o=0; a pready_i coinciding with the limit cycle wins
//   (normal completion).
// - APB_TIMEOUT_EN undefined: no counter; ACCESS waits for pready_i indefinitely.
// TESTING
// - Write addr=0x10 wdata=0x0003_0002 strb=0xF, pready=1 at once -> SETUP then ACCESS
//   1 cycle each, rsp_valid 3 cycles after accept, rdata=0, slverr=0.
// - Read addr=0x20, pready low 3 ACCESS cycles, prdata=0x0000_0007 -> penable high
//   4 cycles, paddr stable, rsp_rdata=0x7 at cycle 6, pstrb_o=0.
// - Write with pslverr=1 at pready -> rsp_slverr=1; next request proceeds normally.
// - rsp_ready held low 5 cycles -> rsp_valid/rdata stable, req_ready=0, psel=0 throughout.
// - rst_ni low during ACCESS -> psel/penable/rsp_valid 0 immediately; after release
//   req_ready=1 and a new read completes correctly.
// - APB_TIMEOUT_EN, TIMEOUT_CYC=8, pready never high -> rsp_valid with slverr=1,
//   rdata=0 after 8 ACCESS cycles; without macro, still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/matmul_apb_initiator.sv
// APB requester for the matmul accelerator: turns valid/ready register requests into APB transfers.
// Optional ACCESS-phase watchdog is compiled in with `define APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a new request (req_ready_o=1)
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready
// RESP   | response held until rsp_ready_i
module matmul_apb_initiator #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [BUS_WIDTH-1:0]   req_wdata_i,
  input  logic [BUS_WIDTH/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
  output logic                   rsp_slverr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [ADDR_WIDTH-1:0]  paddr_o,
  output logic [BUS_WIDTH-1:0]   pwdata_o,
  output logic [BUS_WIDTH/8-1:0] pstrb_o,
  input  logic [BUS_WIDTH-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int StrbW = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [BUS_WIDTH-1:0]   rsp_rdata_q;
  logic                   rsp_slverr_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [BUS_WIDTH-1:0]   pwdata_q;
  logic [StrbW-1:0]       pstrb_q;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] wait_cnt_q;
  logic            tmo_hit;
  // The cycle that would bring the count to the limit is the last one waited.
  assign tmo_hit = (wait_cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
  localparam int unsigned UnusedTimeoutCyc = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= req_write_i;
            paddr_q     <= req_addr_i;
            pwdata_q    <= req_wdata_i;
            pstrb_q     <= req_write_i ? req_strb_i : '0;
            state_q     <= SETUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q    <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q  <= pwrite_q ? '0 : prdata_i;
            rsp_slverr_q <= pslverr_i;
            rsp_valid_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b1;
            rsp_valid_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_slverr_o = rsp_slverr_q;
  assign psel_o       = psel_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;

endmodule
